// File: rtl/serializador.sv
// ============================================================================
// Module   : serializador
// Purpose  : Byte FIFO feeding an MSB-first bit-serial transmitter with a
//            per-byte status handshake toward the receiving deserializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializador #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_100KHz,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic                     in_ready,
    input  logic                     status_in,
    output logic                     data_out,
    output logic                     write_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              bytes_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [7:0]      shreg_q;
    logic [2:0]      bitcnt_q;
    logic            data_out_q;
    logic            write_out_q;
    logic [15:0]     bytes_sent_q;
    logic            push;
    logic            pop;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    always_comb begin
        push    = data_valid && in_ready;
        pop     = (state_q == IDLE) && (count_q != '0) && !status_in;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign in_ready   = (count_q != FULL_COUNT);
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign bytes_sent = bytes_sent_q;
    assign data_out   = data_out_q;
    assign write_out  = write_out_q;

    always_ff @(posedge clk_100KHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            data_out_q   <= 1'b0;
            write_out_q  <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    write_out_q <= 1'b0;
                    data_out_q  <= 1'b0;
                    if (pop) begin
                        shreg_q  <= mem_q[rd_ptr_q];
                        bitcnt_q <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_out_q  <= shreg_q[7];
                    write_out_q <= 1'b1;
                    shreg_q     <= {shreg_q[6:0], 1'b0};
                    bitcnt_q    <= bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    write_out_q <= 1'b0;
                    data_out_q  <= 1'b0;
                    if (status_in) begin
                        state_q <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    write_out_q <= 1'b0;
                    data_out_q  <= 1'b0;
                    if (!status_in) begin
                        bytes_sent_q <= bytes_sent_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    write_out_q <= 1'b0;
                    data_out_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serializador.sv
// ============================================================================
// Module   : tb_serializador
// Purpose  : Self-checking bench for serializador with a behavioural receiver.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serializador;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        in_ready;
    logic        status_in;
    logic        data_out;
    logic        write_out;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] bytes_sent;

    logic        auto_mode;
    logic        status_man;
    logic        rx_status;

    int tests = 0;
    int fails = 0;

    serializador #(.DEPTH(DEPTH)) dut (
        .clk_100KHz (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .in_ready   (in_ready),
        .status_in  (status_in),
        .data_out   (data_out),
        .write_out  (write_out),
        .busy       (busy),
        .fifo_count (fifo_count),
        .bytes_sent (bytes_sent)
    );

    assign status_in = auto_mode ? rx_status : status_man;

    initial clk = 1'b0;
    always #5000 clk = ~clk;

    // Behavioural deserializer: shift-left assembly, ack two cycles after a full byte.
    logic [7:0] rx_q [$];
    int         run_q [$];
    logic [7:0] rx_sh;
    int         rx_n, run, ack_dly, hold, viol;

    initial begin
        rx_status = 1'b0; rx_sh = 8'h00; rx_n = 0; run = 0;
        ack_dly = 0; hold = 0; viol = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            rx_sh = 8'h00; rx_n = 0; run = 0; ack_dly = 0; hold = 0; rx_status = 1'b0;
        end else begin
            if (write_out) begin
                if (auto_mode && rx_status) viol++;
                rx_sh = {rx_sh[6:0], data_out};
                rx_n++;
                run++;
                if (rx_n == 8) begin
                    rx_q.push_back(rx_sh);
                    rx_n    = 0;
                    ack_dly = 2;
                end
            end else if (run != 0) begin
                run_q.push_back(run);
                run = 0;
            end
            if (ack_dly != 0) begin
                ack_dly--;
                if (ack_dly == 0) begin
                    rx_status = 1'b1;
                    hold      = 3;
                end
            end else if (hold != 0) begin
                hold--;
                if (hold == 0) rx_status = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            chk({nm, " strobe"}, 32'(write_out), 32'd1);
            chk({nm, " bit"}, 32'(data_out), 32'(b[i]));
        end
    endtask

    // Offers bytes to the producer port; retry=0 drops a byte the FIFO refuses.
    logic [7:0] exp_q [$];
    task automatic stream(input logic [7:0] bytes [$], input int pct, input bit retry);
        int i = 0;
        int guard = 0;
        while (i < bytes.size() && guard < 5000) begin
            data_valid = ($urandom_range(99) < pct);
            data_in    = bytes[i];
            if (data_valid && in_ready) begin
                exp_q.push_back(bytes[i]);
                i++;
            end else if (data_valid && !retry) begin
                i++;
            end
            guard++;
            @(negedge clk);
        end
        data_valid = 1'b0;
        if (guard >= 5000) chk("stream timeout", 32'(i), 32'(bytes.size()));
    endtask

    task automatic run_stream(input string nm, input logic [7:0] bytes [$], input int pct, input bit retry);
        int rb, wb, guard;
        do_reset();
        auto_mode = 1'b1;
        exp_q.delete();
        rb = rx_q.size();
        wb = run_q.size();
        stream(bytes, pct, retry);
        guard = 0;
        while ((rx_q.size() - rb) < exp_q.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        cyc(15);
        chk({nm, " count"}, 32'(rx_q.size() - rb), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && (rb + k) < rx_q.size(); k++)
            chk({nm, " byte"}, 32'(rx_q[rb + k]), 32'(exp_q[k]));
        chk({nm, " bytes_sent"}, 32'(bytes_sent), 32'(exp_q.size()));
        for (int k = wb; k < run_q.size(); k++)
            chk({nm, " run len"}, 32'(run_q[k]), 32'd8);
        chk({nm, " busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic [2:0] exp_count;
        logic       exp_ready;
    } vec_t;

    initial begin
        vec_t       fill [6];
        logic [7:0] bl [$];
        int         strobes, rb;

        fill[0] = '{1'b0, 8'h00, 3'd0, 1'b1};
        fill[1] = '{1'b1, 8'h01, 3'd1, 1'b1};
        fill[2] = '{1'b1, 8'h02, 3'd2, 1'b1};
        fill[3] = '{1'b1, 8'h03, 3'd3, 1'b1};
        fill[4] = '{1'b1, 8'h04, 3'd4, 1'b0};
        fill[5] = '{1'b1, 8'h05, 3'd4, 1'b0};

        auto_mode = 1'b0; status_man = 1'b0;
        data_valid = 1'b0; data_in = 8'h00; reset = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst write_out", 32'(write_out), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        chk("rst bytes_sent", 32'(bytes_sent), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // 0xA5 then 0x3C; second push coincides with the first pop
        data_valid = 1'b1; data_in = 8'hA5;
        @(negedge clk);
        data_in = 8'h3C;
        chk("push count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        data_valid = 1'b0;
        chk("pop edge strobe", 32'(write_out), 32'd0);
        chk("pop edge busy", 32'(busy), 32'd1);
        chk("simul push/pop count", 32'(fifo_count), 32'd1);
        expect_byte("A5", 8'hA5);
        @(negedge clk);
        chk("after A5 strobe", 32'(write_out), 32'd0);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            strobes += 32'(write_out);
        end
        chk("gated strobes", 32'(strobes), 32'd0);
        chk("gated busy", 32'(busy), 32'd1);
        status_man = 1'b1;
        cyc(3);
        status_man = 1'b0;
        @(negedge clk);
        chk("A5 bytes_sent", 32'(bytes_sent), 32'd1);
        chk("A5 busy", 32'(busy), 32'd0);
        chk("A5 idle strobe", 32'(write_out), 32'd0);
        @(negedge clk);
        chk("3C pop strobe", 32'(write_out), 32'd0);
        expect_byte("3C", 8'h3C);
        status_man = 1'b1;
        cyc(3);
        status_man = 1'b0;
        cyc(1);
        chk("3C bytes_sent", 32'(bytes_sent), 32'd2);

        // Fill with FSM held off by status_in high
        do_reset();
        status_man = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_valid = fill[i].dv;
            data_in    = fill[i].d;
            @(negedge clk);
            chk("fill count", 32'(fifo_count), 32'(fill[i].exp_count));
            chk("fill in_ready", 32'(in_ready), 32'(fill[i].exp_ready));
        end
        data_valid = 1'b0;
        rb = rx_q.size();
        auto_mode = 1'b1;
        for (int g = 0; g < 400 && (rx_q.size() - rb) < 4; g++) @(negedge clk);
        cyc(30);
        chk("fill rx count", 32'(rx_q.size() - rb), 32'd4);
        for (int k = 0; k < 4 && (rb + k) < rx_q.size(); k++)
            chk("fill rx byte", 32'(rx_q[rb + k]), 32'(k + 1));
        chk("fill bytes_sent", 32'(bytes_sent), 32'd4);

        // Reset in the middle of 0xFF with two bytes queued
        auto_mode = 1'b0; status_man = 1'b0;
        do_reset();
        data_valid = 1'b1; data_in = 8'hFF;
        @(negedge clk);
        data_in = 8'h11;
        @(negedge clk);
        data_in = 8'h22;
        @(negedge clk);
        data_valid = 1'b0;
        cyc(2);
        chk("mid strobe", 32'(write_out), 32'd1);
        chk("mid queued", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("async write_out", 32'(write_out), 32'd0);
        chk("async data_out", 32'(data_out), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        repeat (12) begin
            @(negedge clk);
            strobes += 32'(write_out);
        end
        chk("post-reset strobes", 32'(strobes), 32'd0);
        chk("post-reset count", 32'(fifo_count), 32'd0);
        chk("post-reset bytes_sent", 32'(bytes_sent), 32'd0);

        // Pointer wrap with interleaved pushes and pops
        bl.delete();
        for (int i = 0; i < 10; i++) bl.push_back(8'(8'h10 + i));
        run_stream("wrap", bl, 60, 1'b1);

        // Loopback patterns
        bl = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
        run_stream("loop", bl, 100, 1'b1);

        // Random bytes offered once each; refused bytes are lost
        bl.delete();
        for (int i = 0; i < 40; i++) bl.push_back(8'($urandom));
        run_stream("rand", bl, 70, 1'b0);

        chk("strobe during status", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/serializador.md
# serializador

Parallel-to-serial transmitter for the team's bit-serial byte link. It accepts bytes from an upstream producer into a small FIFO and shifts each byte out MSB-first as 8 consecutive `data_out`/`write_out` strobes. After each byte it waits for the receiving deserializer's status handshake before sending the next one. It sits between the byte producer and the serial link, on the transmitting end of the same 1-bit data plus write-strobe interface.

## Interface
- `DEPTH`, default 4: byte FIFO depth. Must be a power of 2, at least 2.
- `clk_100KHz` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `data_in` in 8: byte offered by the producer.
- `data_valid` in 1: producer push request; the byte is accepted on an edge where `data_valid && in_ready`.
- `in_ready` out 1: FIFO not full (combinational from registered occupancy).
- `status_in` in 1: receiver status. High means the receiver holds a completed byte and is not accepting bits.
- `data_out` out 1: serial bit, registered.
- `write_out` out 1: serial strobe, registered; the receiver samples `data_out` on every edge where it is high.
- `busy` out 1: high in any state other than IDLE.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.
- `bytes_sent` out 16: count of completed byte transfers; wraps from 0xFFFF to 0.

## Operation
- Reset values:
  - `data_out`=0, `write_out`=0, `busy`=0, `fifo_count`=0, `bytes_sent`=0, `in_ready`=1.
  - FIFO pointers = 0, shift register = 0, bit counter = 0, state = IDLE.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - Push when `data_valid && in_ready`. Pop only on the IDLE->SHIFT transition.
  - Simultaneous push and pop leaves `fifo_count` unchanged. A push while full is dropped, even if a pop occurs on the same edge.
- States:
  - IDLE:
    - Outputs: `write_out`<=0, `data_out`<=0.
    - If FIFO not empty and `status_in`=0: load the head byte into the shift register, pop, clear the bit counter, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each edge: `data_out`<=shreg[7], `write_out`<=1, shreg<=shreg<<1, bit counter +1.
    - When the bit counter is 7 on this edge (the 8th bit), go to WAIT_HI.
    - `status_in` is ignored in SHIFT.
  - WAIT_HI:
    - Outputs: `write_out`<=0, `data_out`<=0.
    - Stay until `status_in`=1, then go to WAIT_LO.
  - WAIT_LO:
    - Stay until `status_in`=0.
    - On that edge: `bytes_sent` +1, go to IDLE.
  - Any illegal state encoding goes to IDLE.
- Bit order: MSB first, so the receiver's shift-left assembly reproduces the original byte.
- `status_in` must be seen both rising and falling after every byte. This prevents starting the next byte during the receiver's one-cycle status latency.

## Timing
- Push to first bit:
  - Byte pushed on edge P into an empty FIFO with the FSM in IDLE and `status_in`=0.
  - Pop on edge P+1.
  - `write_out` high after edges P+2 through P+9, i.e. exactly 8 consecutive cycles.
  - `write_out` low after edge P+10.
- No gap cycles within a byte; `write_out` never drops mid-byte.
- Minimum inter-byte spacing:
  - 8 cycles of bits, then 1 cycle each in WAIT_HI, WAIT_LO and IDLE beyond the receiver's handshake.
  - The next byte's first bit appears no earlier than 2 edges after `status_in` is seen low.
- `fifo_count` and `in_ready` update on the edge after the push or pop.
- Reset asserted mid-byte:
  - `write_out` and `data_out` drop to 0 immediately (asynchronously).
  - FIFO contents are discarded and the partial byte is not resumed.
- `status_in` already high in IDLE: hold in IDLE with `write_out`=0 until it goes low.

## Test plan
- Single byte 0xA5 pushed, `status_in` held 0:
  - 8 consecutive `write_out` cycles with `data_out` = 1,0,1,0,0,1,0,1.
  - FSM then stays in WAIT_HI.
  - Pulse `status_in` high for 3 cycles, then low: `bytes_sent`=1, `busy`=0.
- Fill test, DEPTH=4, FSM held off with `status_in`=1:
  - Push 0x01..0x04: `fifo_count`=4, `in_ready`=0.
  - 5th push of 0x05 is dropped.
  - Release `status_in` and complete handshakes: exactly 0x01..0x04 emitted, in order.
- Handshake gating:
  - After the 8th bit, hold `status_in`=0 for 20 cycles: no new `write_out`, FSM stays in WAIT_HI.
  - `status_in` 1 then 0: next byte starts 2 edges after the fall.
- Reset mid-operation:
  - Assert `reset` after the 3rd bit of 0xFF with 2 bytes queued.
  - Outputs 0 immediately; after release, `fifo_count`=0 and no strobes appear.
- Pointer wrap:
  - Stream 10 bytes 0x10..0x19 with pushes interleaved with pops, including simultaneous push and pop.
  - All 10 bytes are emitted in order; `bytes_sent`=10.
- Loopback with the team's deserializer, which returns an ack 2 cycles after its `data_ready`:
  - Send 0x00, 0xFF, 0x3C, 0xC3.
  - The receiver's `data_out` matches each byte.
